seg_scan_rx: RTL

- Receive side of the multiplexed 7-segment display interface, the inverse of the display driver.
- Samples the scanned digit-select and segment buses and decodes each segment pattern back to a BCD nibble.
- Assembles the six digits into a frame and publishes it only after it has been stable for several scan frames.
- Serves as on-chip readback/self-check of what the display actually shows (clock, date, stopwatch, alarm modes).

---
 rtl/seg_scan_rx_if.sv | 8 +
 rtl/seg_scan_rx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_rx_if.sv
// Scanned display bus: one-hot-low digit select plus active-low segments.
interface seg_scan_rx_if;
    logic [5:0] seg_sel;
    logic [7:0] seg_led;

    modport master (output seg_sel, output seg_led);
    modport slave  (input  seg_sel, input  seg_led);
endinterface

// File: rtl/seg_scan_rx.sv
// Receive side of the multiplexed 7-segment display: samples each settled
// digit, decodes it back to BCD, and publishes a six-digit frame once the
// same frame has been seen STABLE_FRAMES times in a row.
module seg_scan_rx #(
    parameter int unsigned SETTLE_CYC    = 16,
    parameter int unsigned STABLE_FRAMES = 3,
    parameter int unsigned TIMEOUT_CYC   = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_rx_if.slave       scan,
    output logic [23:0]        digit_data,
    output logic [5:0]         dp_data,
    output logic               frame_valid,
    output logic               decode_err,
    output logic               scan_lost,
    input  logic               err_clr
);

    localparam int unsigned SEL_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned ST_W  = $clog2(STABLE_FRAMES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(SETTLE_CYC);
    localparam logic [SEL_W-1:0] SEL_HIT = SEL_W'(SETTLE_CYC - 1);
    localparam logic [ST_W-1:0]  ST_MAX  = ST_W'(STABLE_FRAMES);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYC);

    logic [5:0]       sel_q, sel_d;
    logic [7:0]       led_q, led_d;
    logic             clr_q, clr_d;
    logic [SEL_W-1:0] sel_cnt_q, sel_cnt_d;
    logic [23:0]      shadow_q, shadow_d;
    logic [5:0]       shadow_dp_q, shadow_dp_d;
    logic [5:0]       captured_q, captured_d;
    logic [29:0]      prev_q, prev_d;
    logic [ST_W-1:0]  stable_q, stable_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [23:0]      digit_q, digit_d;
    logic [5:0]       dp_q, dp_d;
    logic             fv_q, fv_d;
    logic             err_q, err_d;
    logic             lost_q, lost_d;

    logic [6:0]       seg;
    logic [3:0]       nib;
    logic             bad_pat;
    logic             settled;
    logic             sample;
    logic             new_err;
    logic             frame_done;

    // Segment pattern (active high, g..a) back to a BCD nibble.
    always_comb begin
        seg     = ~led_q[6:0];
        bad_pat = 1'b0;
        case (seg)
            7'h3F:   nib = 4'h0;
            7'h06:   nib = 4'h1;
            7'h5B:   nib = 4'h2;
            7'h4F:   nib = 4'h3;
            7'h66:   nib = 4'h4;
            7'h6D:   nib = 4'h5;
            7'h7D:   nib = 4'h6;
            7'h07:   nib = 4'h7;
            7'h7F:   nib = 4'h8;
            7'h6F:   nib = 4'h9;
            7'h00:   nib = 4'hE;
            default: begin
                nib     = 4'hF;
                bad_pat = 1'b1;
            end
        endcase
    end

    // Dwell tracking, capture, frame assembly, publish, timeout and error flag.
    always_comb begin
        sel_d       = scan.seg_sel;
        led_d       = scan.seg_led;
        clr_d       = err_clr;
        sel_cnt_d   = sel_cnt_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        captured_d  = captured_q;
        prev_d      = prev_q;
        stable_d    = stable_q;
        to_cnt_d    = to_cnt_q;
        digit_d     = digit_q;
        dp_d        = dp_q;
        fv_d        = 1'b0;
        err_d       = err_q;
        lost_d      = lost_q;
        new_err     = 1'b0;
        frame_done  = 1'b0;

        // Counter follows the registered select, so compare the raw input
        // against it: a change seen here restarts the count on the same edge
        // the new value is registered.
        if (scan.seg_sel != sel_q) begin
            sel_cnt_d = '0;
        end else if (sel_cnt_q != SEL_MAX) begin
            sel_cnt_d = sel_cnt_q + SEL_W'(1);
        end

        settled = (sel_cnt_q == SEL_HIT);
        sample  = settled && $onehot(~sel_q);

        if (settled && !$onehot(~sel_q) && !(&sel_q)) begin
            new_err = 1'b1;
        end

        if (sample) begin
            for (int unsigned i = 0; i < 6; i++) begin
                if (!sel_q[i]) begin
                    shadow_d[4*i +: 4] = nib;
                    shadow_dp_d[i]     = ~led_q[7];
                end
            end
            if (bad_pat) begin
                new_err = 1'b1;
            end
            captured_d = captured_q | ~sel_q;
            if (captured_d == '1) begin
                frame_done = 1'b1;
                captured_d = '0;
                prev_d     = {shadow_dp_d, shadow_d};
                if ({shadow_dp_d, shadow_d} == prev_q) begin
                    if (stable_q != ST_MAX) begin
                        stable_d = stable_q + ST_W'(1);
                    end
                end else begin
                    stable_d = ST_W'(1);
                end
                if (stable_d == ST_MAX && stable_q != ST_MAX) begin
                    digit_d = shadow_d;
                    dp_d    = shadow_dp_d;
                    fv_d    = 1'b1;
                end
            end
        end

        if (frame_done) begin
            to_cnt_d = '0;
            lost_d   = 1'b0;
        end else begin
            if (to_cnt_q != TO_MAX) begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
            if (to_cnt_d == TO_MAX) begin
                lost_d = 1'b1;
            end
        end

        if (new_err) begin
            err_d = 1'b1;
        end else if (clr_q) begin
            err_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= '1;
            led_q       <= '1;
            clr_q       <= 1'b0;
            sel_cnt_q   <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            captured_q  <= '0;
            prev_q      <= '0;
            stable_q    <= '0;
            to_cnt_q    <= '0;
            digit_q     <= 24'hEEEEEE;
            dp_q        <= '0;
            fv_q        <= 1'b0;
            err_q       <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            led_q       <= led_d;
            clr_q       <= clr_d;
            sel_cnt_q   <= sel_cnt_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            captured_q  <= captured_d;
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            to_cnt_q    <= to_cnt_d;
            digit_q     <= digit_d;
            dp_q        <= dp_d;
            fv_q        <= fv_d;
            err_q       <= err_d;
            lost_q      <= lost_d;
        end
    end

    assign digit_data  = digit_q;
    assign dp_data     = dp_q;
    assign frame_valid = fv_q;
    assign decode_err  = err_q;
    assign scan_lost   = lost_q;

endmodule
